// File: rtl/mux8_scan_pkg.sv
// Shared types and select-code helpers for the mux8 scan sequencer.
package mux8_scan_pkg;

    localparam int SEL_W = 3;
    localparam int NCH   = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    function automatic logic [SEL_W-1:0] start_code(input bit descend);
        logic [SEL_W-1:0] v;
        v = descend ? SEL_W'(NCH - 1) : '0;
        return v;
    endfunction

    function automatic logic [SEL_W-1:0] end_code(input bit descend);
        logic [SEL_W-1:0] v;
        v = descend ? '0 : SEL_W'(NCH - 1);
        return v;
    endfunction

endpackage

// File: rtl/mux8_scan_seq_if.sv
// Load and serial-stream handshakes of the mux8 scan sequencer.
interface mux8_scan_seq_if;
    import mux8_scan_pkg::*;

    logic           load_valid;
    logic           load_ready;
    logic [NCH-1:0] load_data;
    logic           ser_bit;
    logic           ser_valid;
    logic           ser_ready;
    logic           ser_last;

    modport master (
        input  load_valid, load_data, ser_ready,
        output load_ready, ser_bit, ser_valid, ser_last
    );

    modport slave (
        output load_valid, load_data, ser_ready,
        input  load_ready, ser_bit, ser_valid, ser_last
    );

endinterface

// File: rtl/mux8.sv
// Behavioural 8:1 mux; select code is {s0,s1,s2} with s0 as MSB.
module mux8 (
    input  logic i_i0,
    input  logic i_i1,
    input  logic i_i2,
    input  logic i_i3,
    input  logic i_i4,
    input  logic i_i5,
    input  logic i_i6,
    input  logic i_i7,
    input  logic i_s0,
    input  logic i_s1,
    input  logic i_s2,
    output logic o_out
);

    logic [7:0] w_d;

    assign w_d   = {i_i7, i_i6, i_i5, i_i4, i_i3, i_i2, i_i1, i_i0};
    assign o_out = w_d[{i_s0, i_s1, i_s2}];

endmodule

// File: rtl/mux8_scan_seq_scan_sel_cnt.sv
// Up/down select counter; parks on the end code so it never wraps mid-word.
module scan_sel_cnt
    import mux8_scan_pkg::*;
#(
    parameter bit DESCEND = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic             i_en,
    output logic [SEL_W-1:0] o_sel,
    output logic             o_at_end
);

    logic [SEL_W-1:0] r_sel;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sel <= '0;
        end else if (i_load) begin
            r_sel <= start_code(DESCEND);
        end else if (i_en && !o_at_end) begin
            r_sel <= DESCEND ? r_sel - 1'b1 : r_sel + 1'b1;
        end
    end

    assign o_sel    = r_sel;
    assign o_at_end = (r_sel == end_code(DESCEND));

endmodule

// File: rtl/mux8_scan_seq.sv
// Parallel-in/serial-out sequencer driving an external mux8.
module mux8_scan_seq
    import mux8_scan_pkg::*;
#(
    parameter bit DESCEND  = 1'b0,
    parameter int IDLE_GAP = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    mux8_scan_seq_if.master       if_bus,
    output logic                  o_i0,
    output logic                  o_i1,
    output logic                  o_i2,
    output logic                  o_i3,
    output logic                  o_i4,
    output logic                  o_i5,
    output logic                  o_i6,
    output logic                  o_i7,
    output logic                  o_s0,
    output logic                  o_s1,
    output logic                  o_s2,
    input  logic                  i_mux_out,
    output logic                  o_busy
);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_SHIFT = SHIFT;
    localparam logic [1:0] ST_GAP   = GAP;
    localparam logic [1:0] ST_DONE  = (IDLE_GAP > 0) ? ST_GAP : ST_IDLE;
    localparam logic [3:0] GAP_LAST = 4'(IDLE_GAP - 1);

    logic [1:0]       r_state;
    logic [NCH-1:0]   r_word;
    logic [3:0]       r_gap;
    logic             r_bit;
    logic             r_valid;
    logic             r_last;

    logic             w_idle;
    logic             w_accept;
    logic             w_free;
    logic             w_cap;
    logic             w_at_end;
    logic [SEL_W-1:0] w_sel;

    assign w_idle   = (r_state == ST_IDLE);
    assign w_accept = if_bus.load_valid & if_bus.load_ready;
    assign w_free   = ~r_valid | if_bus.ser_ready;
    assign w_cap    = (r_state == ST_SHIFT) & w_free;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_word  <= '0;
            r_gap   <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_word  <= if_bus.load_data;
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (w_cap && w_at_end) begin
                        r_state <= ST_DONE;
                        r_gap   <= '0;
                    end
                end
                ST_GAP: begin
                    if (r_gap == GAP_LAST) begin
                        r_state <= ST_IDLE;
                        r_gap   <= '0;
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // A capture on the consume edge refills the register: no bubble.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_bit   <= 1'b0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else if (w_cap) begin
            r_bit   <= i_mux_out;
            r_valid <= 1'b1;
            r_last  <= w_at_end;
        end else if (r_valid && if_bus.ser_ready) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end
    end

    scan_sel_cnt #(
        .DESCEND (DESCEND)
    ) u_sel (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_load   (w_accept),
        .i_en     (w_cap),
        .o_sel    (w_sel),
        .o_at_end (w_at_end)
    );

    assign if_bus.load_ready = ~i_rst & w_idle;
    assign if_bus.ser_bit    = r_bit;
    assign if_bus.ser_valid  = r_valid;
    assign if_bus.ser_last   = r_last;

    assign o_busy = ~i_rst & ~w_idle;
    assign {o_s0, o_s1, o_s2} = w_sel;
    assign {o_i7, o_i6, o_i5, o_i4, o_i3, o_i2, o_i1, o_i0} = r_word;

endmodule
